// File: rtl/score4_pkg.sv
// Shared types for the score4 input front end: move codes, FSM states and press arbitration.
package score4_pkg;

  typedef enum logic [1:0] {MV_NONE, MV_LEFT, MV_RIGHT, MV_PUT} move_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FIRE} state_t;

  // Same-cycle presses resolve as put > right > left; losers are dropped.
  function automatic move_t arbitrate(input logic left_ev, input logic right_ev,
                                      input logic put_ev);
    move_t mv;
    mv = MV_NONE;
    if (put_ev)        mv = MV_PUT;
    else if (right_ev) mv = MV_RIGHT;
    else if (left_ev)  mv = MV_LEFT;
    return mv;
  endfunction

endpackage

// File: rtl/score4_input_ctrl_if.sv
// Button/frame inputs and move-pulse outputs between the input controller and its user.
interface score4_input_ctrl_if;
  logic btn_left_raw;
  logic btn_right_raw;
  logic btn_put_raw;
  logic frame_tick;
  logic lock;
  logic left;
  logic right;
  logic put;
  logic pending;

  modport master (
    output btn_left_raw, btn_right_raw, btn_put_raw, frame_tick, lock,
    input  left, right, put, pending
  );

  modport slave (
    input  btn_left_raw, btn_right_raw, btn_put_raw, frame_tick, lock,
    output left, right, put, pending
  );
endinterface

// File: rtl/score4_debounce.sv
// One button: 2-FF synchroniser, stability counter and one-cycle press (rising edge) event.
module score4_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synced level disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync_q2;
        press <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score4_input_ctrl.sv
// Debounces three buttons, arbitrates presses and releases at most one move pulse per frame.
module score4_input_ctrl
  import score4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  rst,
  score4_input_ctrl_if.slave   bus
);

  logic   lvl_left, lvl_right, lvl_put;
  logic   prs_left, prs_right, prs_put;
  move_t  ev_move;
  move_t  slot, slot_nxt;
  move_t  fire_move;
  state_t state, state_nxt;

  score4_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .raw(bus.btn_left_raw), .level(lvl_left), .press(prs_left)
  );

  score4_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .raw(bus.btn_right_raw), .level(lvl_right), .press(prs_right)
  );

  score4_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_put (
    .clk(clk), .rst(rst), .raw(bus.btn_put_raw), .level(lvl_put), .press(prs_put)
  );

  // A press event is only honoured while its settled level is still high.
  assign ev_move = arbitrate(prs_left & lvl_left, prs_right & lvl_right, prs_put & lvl_put);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      slot        <= MV_NONE;
      bus.left    <= 1'b0;
      bus.right   <= 1'b0;
      bus.put     <= 1'b0;
      bus.pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      bus.left    <= (fire_move == MV_LEFT);
      bus.right   <= (fire_move == MV_RIGHT);
      bus.put     <= (fire_move == MV_PUT);
      bus.pending <= (state_nxt == ST_HOLD);
    end
  end

  // One-deep move slot: first press wins, released on the next frame tick.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    fire_move = MV_NONE;
    case (state)
      ST_IDLE: begin
        if (ev_move != MV_NONE) begin
          state_nxt = ST_HOLD;
          slot_nxt  = ev_move;
        end
      end
      ST_HOLD: begin
        if (bus.frame_tick) state_nxt = ST_FIRE;
      end
      ST_FIRE: begin
        state_nxt = ST_IDLE;
        slot_nxt  = MV_NONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        slot_nxt  = MV_NONE;
      end
    endcase
    if (bus.lock) begin
      state_nxt = ST_IDLE;
      slot_nxt  = MV_NONE;
    end
    if (state_nxt == ST_FIRE) fire_move = slot_nxt;
  end

endmodule
